// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// The frame state encoding carries a PARITY_BIT state only when
// UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd4
  } uart_state_e;
`endif

  // Line levels for the framing bits; the idle line sits at the stop level.
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = STOP_LEVEL;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Oversample counter: counts 0..OVERSAMPLE-1 while running and flags the
// last cycle of each serial bit. A synchronous clear restarts the bit.
module uart_baud_cnt #(
  parameter int OVERSAMPLE = 16,
  parameter int CW         = $clog2(OVERSAMPLE)
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_bit_tick
);

  logic [CW-1:0] r_count;

  // The tick marks the final cycle of a bit; the counter wraps on it.
  assign o_bit_tick = i_run && (r_count == CW'(OVERSAMPLE - 1));

  // Count while a bit is being held, restart at each bit boundary.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= o_bit_tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional even parity
// bit (UART_TX_PARITY_EN), then STOP_BITS stop bits. Each bit lasts
// OVERSAMPLE clocks. The serial line is driven from a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       tx_Clk,
  input  logic       tx_Rst,
  input  logic       enable,
  input  logic [7:0] i_TX_byte,
  input  logic       i_TX_valid,
  output logic       o_TX_ready,
  output logic       o_TX_serial,
  output logic       o_TX_active,
  output logic       o_TX_done
);

  uart_state_e r_state;
  uart_state_e w_state_next;
  logic [7:0]  r_data;
  logic [7:0]  w_data_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic        r_stop_idx;
  logic        w_stop_idx_next;
  logic        r_serial;
  logic        w_serial_next;
  logic        r_done;
  logic        w_done_next;
  logic        w_bit_tick;
  logic        w_baud_clr;
  logic        w_baud_run;

  // The bit timer runs only inside a frame and is held at zero otherwise.
  assign w_baud_run = (r_state != IDLE);
  assign w_baud_clr = !enable || (r_state == IDLE);

  uart_baud_cnt #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_cnt (
    .i_clk      (tx_Clk),
    .i_srst     (tx_Rst),
    .i_clr      (w_baud_clr),
    .i_run      (w_baud_run),
    .o_bit_tick (w_bit_tick)
  );

  assign o_TX_ready  = enable && (r_state == IDLE);
  assign o_TX_active = (r_state != IDLE);
  assign o_TX_serial = r_serial;
  assign o_TX_done   = r_done;

  // Frame sequencing; the next line level is derived from the next state so
  // the registered serial output changes on the same edge as the state.
  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_done_next     = 1'b0;
    w_serial_next   = IDLE_LEVEL;

    if (!enable) begin
      w_state_next    = IDLE;
      w_bit_idx_next  = '0;
      w_stop_idx_next = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_TX_valid) begin
            w_state_next    = START_BIT;
            w_data_next     = i_TX_byte;
            w_bit_idx_next  = '0;
            w_stop_idx_next = 1'b0;
          end
        end
        START_BIT: begin
          if (w_bit_tick) w_state_next = DATA_BITS;
        end
        DATA_BITS: begin
          if (w_bit_tick) begin
            // Wraps 7 -> 0, leaving the index ready for the next frame.
            w_bit_idx_next = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              w_state_next = PARITY_BIT;
`else
              w_state_next = STOP_BIT;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          if (w_bit_tick) w_state_next = STOP_BIT;
        end
`endif
        STOP_BIT: begin
          if (w_bit_tick) begin
            if (r_stop_idx == 1'(STOP_BITS - 1)) begin
              w_state_next    = IDLE;
              w_stop_idx_next = 1'b0;
              w_done_next     = 1'b1;
            end else begin
              w_stop_idx_next = r_stop_idx + 1'b1;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end

    case (w_state_next)
      START_BIT:  w_serial_next = START_LEVEL;
      DATA_BITS:  w_serial_next = w_data_next[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: w_serial_next = even_parity(w_data_next);
`endif
      STOP_BIT:   w_serial_next = STOP_LEVEL;
      default:    w_serial_next = IDLE_LEVEL;
    endcase
  end

  // State and datapath registers; reset wins over enable and any frame.
  always_ff @(posedge tx_Clk) begin
    if (tx_Rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_serial   <= IDLE_LEVEL;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_serial   <= w_serial_next;
      r_done     <= w_done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx. Accepted bytes are queued by a handshake
// recorder; an independent monitor captures each frame from the line and
// compares it to a bit-list model of the expected waveform.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME  = (9 + PBITS + 1) * OS;
  localparam int FRAME2 = (9 + PBITS + 2) * OS;
  localparam int LW     = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, serial, active, done;
  logic       en2 = 1'b1;
  logic       valid2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       ready2, serial2, active2, done2;

  uart_tx #(.OVERSAMPLE(OS), .STOP_BITS(1)) u_dut (
    .tx_Clk(clk), .tx_Rst(rst), .enable(en), .i_TX_byte(data),
    .i_TX_valid(valid), .o_TX_ready(ready), .o_TX_serial(serial),
    .o_TX_active(active), .o_TX_done(done)
  );

  uart_tx #(.OVERSAMPLE(OS), .STOP_BITS(2)) u_dut2 (
    .tx_Clk(clk), .tx_Rst(rst), .enable(en2), .i_TX_byte(data2),
    .i_TX_valid(valid2), .o_TX_ready(ready2), .o_TX_serial(serial2),
    .o_TX_active(active2), .o_TX_done(done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } exp_t;
  exp_t exp_q[$];
  bit mon_en   = 1'b0;
  bit mon_busy = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected line waveform, one entry per clock: list the bit levels of the
  // frame, then stretch each to OS cycles.
  function automatic logic [LW-1:0] model_line(input logic [7:0] b, input int sb);
    bit            lv[$];
    logic [LW-1:0] v;
    int            k;
    v = '0;
    k = 0;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    lv.push_back(^b);
`endif
    for (int i = 0; i < sb; i++) lv.push_back(1'b1);
    foreach (lv[j]) begin
      for (int r = 0; r < OS; r++) begin
        v[k] = lv[j];
        k++;
      end
    end
    return v;
  endfunction

  // Handshake recorder: a byte is committed when valid and ready coincide.
  always @(negedge clk) begin
    if (!rst && valid && ready) exp_q.push_back('{b: data, acc: cyc});
  end

  // Monitor: a falling line opens a frame; capture it cycle by cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && serial == 1'b0) begin : frame_blk
        exp_t          e;
        logic [LW-1:0] line;
        bit            act_ok, rdy_ok, dn_ok;
        int            start;
        mon_busy = 1'b1;
        start  = cyc;
        line   = '0;
        act_ok = 1'b1;
        rdy_ok = 1'b1;
        dn_ok  = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          line[k] = serial;
          if (active !== 1'b1) act_ok = 1'b0;
          if (ready !== 1'b0) rdy_ok = 1'b0;
          if (done !== 1'b0) dn_ok = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_line_idle", serial, 1);
        check("done_active_low", active, 0);
        check("done_ready", ready, 1);
        check("frame_active", act_ok, 1);
        check("frame_not_ready", rdy_ok, 1);
        check("frame_no_early_done", dn_ok, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_frame: line %0h with no accepted byte", line);
        end else begin
          e = exp_q.pop_front();
          check("frame_line", line, model_line(e.b, 1));
          check("start_latency", start - e.acc, 1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte; while the DUT is busy, valid stays high with junk data
  // that must be ignored. Returns the cycle of the handshake.
  task automatic send(input logic [7:0] b, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    forever begin
      tick();
      if (ready) begin
        data  = b;
        valid = 1'b1;
        acc   = cyc;
        tick();
        break;
      end
      data  = 8'($urandom);
      valid = 1'b1;
      guard++;
      if (guard > 1000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: ready=%0b expected 1", ready);
        valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    valid = 1'b0;
    while ((exp_q.size() != 0 || mon_busy || active) && g < 3000) begin
      tick();
      g++;
    end
    check("drain_in_time", (g < 3000), 1);
  endtask

  task automatic abort_en(input int at);
    logic [LW-1:0] ref_line;
    bit            quiet;
    ref_line = model_line(8'hFF, 1);
    check("abort_ready_before", ready, 1);
    data  = 8'hFF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (at - 1) tick();
    check("abort_line_before", serial, ref_line[at-1]);
    check("abort_active_before", active, 1);
    en = 1'b0;
    tick();
    check("abort_line_high", serial, 1);
    check("abort_active_low", active, 0);
    check("abort_no_done", done, 0);
    check("abort_ready_low", ready, 0);
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (serial !== 1'b1 || done !== 1'b0 || active !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1);
    en = 1'b1;
    #1;
    check("abort_ready_again", ready, 1);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dk, donek, cnt, gap;
    logic [7:0]    b;
    logic [LW-1:0] line;

    repeat (3) tick();
    check("rst_line", serial, 1);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", ready, 1);
    en = 1'b0;
    #1;
    check("ready_needs_enable", ready, 0);
    en = 1'b1;
    mon_en = 1'b1;

    // 0x55 with an explicit done-cycle count.
    send(8'h55, a1);
    valid = 1'b0;
    dk = -1;
    for (int j = 2; j <= 300 && dk < 0; j++) begin
      tick();
      if (done) dk = j;
    end
    check("x55_done_cycle", dk, FRAME + 1);
    drain();

    // Back-to-back: the second byte must go in on the done cycle.
    send(8'hA5, a1);
    send(8'h3C, a2);
    idle(1);
    check("b2b_accept_gap", a2 - a1, FRAME + 1);
    drain();

`ifdef UART_TX_PARITY_EN
    send(8'h07, a1);
    idle(1);
    send(8'h03, a1);
    idle(1);
    drain();
`endif

    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 2);
      send(b, a1);
      if (gap > 0) begin
        drain();
        idle(gap);
      end
    end
    drain();

    // Enable drops mid-frame: data bits and start bit.
    mon_en = 1'b0;
    abort_en(50);
    abort_en(8);

    // Reset in the middle of the data bits, then a clean frame.
    check("rst_test_ready", ready, 1);
    data  = 8'h00;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (39) tick();
    check("rst_line_before", serial, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_line", serial, 1);
    check("midrst_active", active, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", ready, 1);
    exp_q.delete();
    mon_en = 1'b1;
    send(8'h81, a1);
    idle(1);
    drain();

    // Two stop bits on the second instance.
    check("d2_ready", ready2, 1);
    data2  = 8'h00;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    line  = '0;
    donek = -1;
    for (int k = 1; k <= FRAME2 + 5; k++) begin
      if (k > 1) tick();
      if (k <= FRAME2) line[k-1] = serial2;
      if (done2 === 1'b1 && donek < 0) donek = k;
    end
    check("d2_frame_line", line, model_line(8'h00, 2));
    check("d2_done_cycle", donek, FRAME2 + 1);
    cnt = 0;
    for (int k = FRAME2 - 1; k >= 0; k--) begin
      if (line[k] !== 1'b1) break;
      cnt++;
    end
    check("d2_stop_cycles", cnt, 2 * OS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
